// File: rtl/out_sym_packer.sv
// ============================================================================
// Module   : out_sym_packer
// Brief    : Packs 2-bit decode-stage symbols LSB-first into words and queues
//            finished words in a small first-word-fall-through FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module out_sym_packer #(
    parameter int SYM_W      = 2,
    parameter int SYMS       = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int WORD_W    = SYM_W * SYMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_nsym,
    output logic              out_last,
    output logic [15:0]       word_cnt
);

    localparam int SLOT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
    logic [15:0]         word_cnt_q;

    logic [WORD_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [2:0]          mem_nsym_q [FIFO_DEPTH];
    logic                mem_last_q [FIFO_DEPTH];

    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                last_slot;
    logic [WORD_W-1:0]   push_word;
    logic [2:0]          push_nsym;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign last_slot = (slot_q == SLOT_W'(SYMS - 1));
    assign push_word = acc_q | (WORD_W'(in_sym) << (SYM_W * int'(slot_q)));
    assign push_nsym = 3'(slot_q) + 3'd1;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        acc_d   = acc_q;
        push    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (in_last || last_slot) begin
                        push = 1'b1;
                    end else begin
                        state_d = PARTIAL;
                        slot_d  = slot_q + SLOT_W'(1);
                        acc_d   = push_word;
                    end
                end
            end
            PARTIAL: begin
                if (accept) begin
                    if (in_last || last_slot) begin
                        push    = 1'b1;
                        state_d = EMPTY;
                        slot_d  = '0;
                        acc_d   = '0;
                    end else begin
                        slot_d  = slot_q + SLOT_W'(1);
                        acc_d   = push_word;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                slot_d  = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            slot_q     <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            acc_q   <= acc_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + (PTR_W + 1)'(1);
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
            mem_nsym_q[wr_ptr_q[PTR_W-1:0]] <= push_nsym;
            mem_last_q[wr_ptr_q[PTR_W-1:0]] <= in_last;
        end
    end

    assign out_data = fifo_empty ? '0   : mem_data_q[rd_ptr_q[PTR_W-1:0]];
    assign out_nsym = fifo_empty ? 3'd0 : mem_nsym_q[rd_ptr_q[PTR_W-1:0]];
    assign out_last = fifo_empty ? 1'b0 : mem_last_q[rd_ptr_q[PTR_W-1:0]];
    assign word_cnt = word_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_out_sym_packer.sv
// ============================================================================
// Module   : tb_out_sym_packer
// Brief    : Self-checking bench for out_sym_packer against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_out_sym_packer;

    localparam int SYMS  = 4;
    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sym;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_nsym;
    logic       out_last;
    logic [15:0] word_cnt;

    out_sym_packer #(
        .SYM_W      (2),
        .SYMS       (SYMS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nsym  (out_nsym),
        .out_last  (out_last),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] n;
        logic       l;
    } word_t;

    word_t      m_q[$];
    logic [1:0] m_part[$];
    logic [15:0] m_wcnt;
    int         m_accepted;
    int         checks;
    int         errors;
    bit         chk_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model state after an edge, derived from symbol/word bookkeeping.
    task automatic model_update(input logic v, input logic [1:0] s, input logic l, input logic ordy);
        bit acc;
        bit pp;
        word_t w;
        if (rst) begin
            m_q.delete();
            m_part.delete();
            m_wcnt = 16'd0;
            return;
        end
        acc = v && (m_q.size() < DEPTH);
        pp  = (m_q.size() > 0) && ordy;
        if (pp) void'(m_q.pop_front());
        if (acc) begin
            m_part.push_back(s);
            m_accepted++;
            if (l || m_part.size() == SYMS) begin
                w.d = 8'd0;
                for (int k = 0; k < m_part.size(); k++)
                    w.d = w.d + (8'(m_part[k]) << (2 * k));
                w.n = 3'(m_part.size());
                w.l = l;
                m_q.push_back(w);
                m_part.delete();
                m_wcnt = m_wcnt + 16'd1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic l, input logic ordy);
        in_valid  = v;
        in_sym    = s;
        in_last   = l;
        out_ready = ordy;
        @(posedge clk);
        model_update(v, s, l, ordy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        m_accepted = 0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            chk("out_data",  32'(out_data),  (m_q.size() > 0) ? 32'(m_q[0].d) : 32'd0);
            chk("out_nsym",  32'(out_nsym),  (m_q.size() > 0) ? 32'(m_q[0].n) : 32'd0);
            chk("out_last",  32'(out_last),  (m_q.size() > 0) ? 32'(m_q[0].l) : 32'd0);
            chk("word_cnt",  32'(word_cnt),  32'(m_wcnt));
        end
    end

    logic [1:0] seq2 [4];

    initial begin
        checks = 0;
        errors = 0;
        chk_on = 1'b0;
        m_wcnt = 16'd0;
        m_accepted = 0;

        // Reset held two cycles with in_valid asserted
        rst = 1'b1;
        step(1'b1, 2'd3, 1'b0, 1'b0);
        chk_on = 1'b1;
        step(1'b1, 2'd3, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);

        // Full word 1,2,3,0
        seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd3; seq2[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq2[i], 1'b0, 1'b1);
            if (i == 2) chk("full_early_valid", 32'(out_valid), 32'd0);
        end
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_data", 32'(out_data), 32'h39);
        chk("full_nsym", 32'(out_nsym), 32'd4);
        chk("full_last", 32'(out_last), 32'd0);
        chk("full_wcnt", 32'(word_cnt), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Flush with in_last
        do_reset();
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b1, 1'b1);
        chk("flush_data", 32'(out_data), 32'h07);
        chk("flush_nsym", 32'(out_nsym), 32'd2);
        chk("flush_last", 32'(out_last), 32'd1);
        step(1'b1, 2'd2, 1'b1, 1'b1);
        chk("single_data", 32'(out_data), 32'h02);
        chk("single_nsym", 32'(out_nsym), 32'd1);
        chk("single_wcnt", 32'(word_cnt), 32'd2);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Backpressure: 12 symbols of 3 into a stalled sink
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_data", 32'(out_data), 32'hFF);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        chk("bp_held_wcnt", 32'(word_cnt), 32'd2);
        for (int i = 0; i < 40 && m_accepted < 12; i++) step(1'b1, 2'd3, 1'b0, 1'b1);
        chk("bp_all_accepted", 32'(m_accepted >= 12), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_wcnt", 32'(word_cnt), 32'd3);

        // Reset mid-frame
        do_reset();
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
        chk("midrst_data", 32'(out_data), 32'h55);
        chk("midrst_nsym", 32'(out_nsym), 32'd4);
        chk("midrst_wcnt", 32'(word_cnt), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // Random valid/ready traffic
        do_reset();
        for (int i = 0; i < 20000 && m_accepted < 3000; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, v ? 2'($urandom) : 2'bxx, v ? ($urandom_range(0, 7) == 0) : 1'bx,
                 ($urandom_range(0, 3) != 0));
        end
        chk("rand_done", 32'(m_accepted >= 3000), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b0, 1'b1);

        // word_cnt wrap: one single-symbol word per cycle
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, 2'($urandom), 1'b1, 1'b1);
        chk("wrap_max", 32'(word_cnt), 32'hFFFF);
        step(1'b1, 2'd1, 1'b1, 1'b1);
        chk("wrap_zero", 32'(word_cnt), 32'd0);
        step(1'b1, 2'd2, 1'b1, 1'b1);
        chk("wrap_one", 32'(word_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b1);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
